download_mem_arbiter: RTL

- Sits between the ROM loader's 8-bit byte-write bus and the single shared memory port that holds image, mask-config and ROM data.
- Buffers loader byte writes in a small FIFO and tags each with its region.
- Arbitrates the memory port between buffered download writes and a runtime read requester (video/mask fetch).
- Drives loader backpressure (ioctl_wait) so no byte is lost in normal operation.

---
 rtl/download_mem_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/download_mem_arbiter.sv
// download_mem_arbiter: buffers ROM-loader byte writes in a small FIFO tagged with their
// region, and arbitrates one shared memory port between those writes and a runtime reader.
// Optional feature macro: DOWNLOAD_CHECKSUM_EN (16-bit running sum of accepted bytes).
module download_mem_arbiter #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_WIDTH = 26
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_8bit,
   input  logic [ADDR_WIDTH-1:0] addr_8bit,
   input  logic [7:0]            data_8bit,
   input  logic                  image_download,
   input  logic                  mask_config_download,
   input  logic                  rom_download,
   output logic                  ioctl_wait,
   output logic                  overflow,
   input  logic                  rd_req,
   input  logic [1:0]            rd_region,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ack,
   output logic [7:0]            rd_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [1:0]            mem_region,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic                  mem_ack,
   input  logic [7:0]            mem_rdata,
   output logic [15:0]           checksum
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned EW = ADDR_WIDTH + 10;

   localparam logic [PW-1:0] PtrOne    = PW'(1);
   localparam logic [CW-1:0] CntOne    = CW'(1);
   localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);
   // Two entries of headroom: the loader may already have a byte pair in flight.
   localparam logic [CW-1:0] WaitLevel = CW'(FIFO_DEPTH - 2);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StWrite = 2'd1;
   localparam logic [1:0] StRead  = 2'd2;

   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    state_q;
   logic          last_read_q;

   logic          any_flag, push_req, push_ok, fifo_empty, fifo_full;
   logic          grant_write, grant_read;
   logic [1:0]    wr_region;
   logic [EW-1:0] head;

   // Region tag with image > mask > ROM priority
   always_comb begin
      wr_region = 2'd0;
      if (image_download)            wr_region = 2'd0;
      else if (mask_config_download) wr_region = 2'd1;
      else if (rom_download)         wr_region = 2'd2;
   end

   assign any_flag   = image_download | mask_config_download | rom_download;
   assign push_req   = wr_8bit & any_flag;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FullCount);
   assign head       = fifo_mem[rd_ptr_q];
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
   assign push_ok    = push_req & (~fifo_full | grant_write);

   // Round-robin grant decision, only evaluated while idle
   always_comb begin
      grant_write = 1'b0;
      grant_read  = 1'b0;
      if (state_q == StIdle) begin
         if (!fifo_empty && rd_req) begin
            grant_write = last_read_q;
            grant_read  = ~last_read_q;
         end else if (!fifo_empty) begin
            grant_write = 1'b1;
         end else if (rd_req) begin
            grant_read = 1'b1;
         end
      end
   end

   // Next FIFO occupancy
   always_comb begin
      count_d = count_q;
      case ({push_ok, grant_write})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage; contents are discarded on reset by clearing the pointers
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= {wr_region, addr_8bit, data_8bit};
   end

   // FIFO pointers, occupancy, backpressure and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ioctl_wait <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok)     wr_ptr_q <= wr_ptr_q + PtrOne;
         if (grant_write) rd_ptr_q <= rd_ptr_q + PtrOne;
         count_q    <= count_d;
         ioctl_wait <= (count_d >= WaitLevel);
         if (push_req && fifo_full && !grant_write) overflow <= 1'b1;
      end
   end

   // Memory port FSM: latch a grant, hold the request until mem_ack, then return to idle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         last_read_q <= 1'b1;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_region  <= 2'd0;
         mem_addr    <= '0;
         mem_wdata   <= 8'h00;
         rd_ack      <= 1'b0;
         rd_data     <= 8'h00;
      end else begin
         rd_ack <= 1'b0;
         case (state_q)
            StIdle: begin
               if (grant_write) begin
                  state_q    <= StWrite;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b1;
                  mem_region <= head[EW-1 -: 2];
                  mem_addr   <= head[ADDR_WIDTH+7:8];
                  mem_wdata  <= head[7:0];
               end else if (grant_read) begin
                  state_q    <= StRead;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_region <= rd_region;
                  mem_addr   <= rd_addr;
                  mem_wdata  <= 8'h00;
               end
            end
            StWrite: begin
               if (mem_ack) begin
                  state_q     <= StIdle;
                  mem_req     <= 1'b0;
                  last_read_q <= 1'b0;
               end
            end
            StRead: begin
               if (mem_ack) begin
                  state_q     <= StIdle;
                  mem_req     <= 1'b0;
                  last_read_q <= 1'b1;
                  rd_data     <= mem_rdata;
                  rd_ack      <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef DOWNLOAD_CHECKSUM_EN
   logic        flags_any_q;
   logic [15:0] checksum_q;

   // Running sum of accepted bytes, restarted when a new download begins
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_any_q <= 1'b0;
         checksum_q  <= 16'h0000;
      end else begin
         flags_any_q <= any_flag;
         if (any_flag && !flags_any_q) begin
            checksum_q <= push_ok ? {8'h00, data_8bit} : 16'h0000;
         end else if (push_ok) begin
            checksum_q <= checksum_q + {8'h00, data_8bit};
         end
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 16'h0000;
`endif

endmodule
